// File: rtl/vga_copy_pkg.sv
// Shared definitions for the VGA frame copy scheduler: address/data sizes,
// words per full copy, framebuffer address width and the FSM state encoding.
package vga_copy_pkg;

   localparam int unsigned VGA_ADDR_W      = 12;
   localparam int unsigned VGA_DATA_W      = 8;
   localparam int unsigned VGA_TIMEOUT_CYC = 16;

   // One full image covers every shared-memory address exactly once.
   localparam int unsigned VGA_WORDS     = 1 << VGA_ADDR_W;
   // Framebuffer holds two images; the MSB selects the buffer.
   localparam int unsigned VGA_FB_ADDR_W = VGA_ADDR_W + 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_WAIT  = 3'd2,
      ST_COPY  = 3'd3,
      ST_CHECK = 3'd4,
      ST_SWAP  = 3'd5
   } vga_copy_state_e;

endpackage

// File: rtl/vga_copy_checker.sv
// Tracks the streamed address sequence and word count of one copy and
// produces the completeness verdict used in the CHECK state.
//   clk, reset : clock, synchronous active-high reset
//   clr        : start of a new copy (count and sequence state cleared)
//   cap        : a streamed word is captured this cycle
//   cap_addr   : address of the captured word
//   words      : captured words so far, saturating at WORDS
//   ok_c       : exactly WORDS words seen, addresses 0,1,2,... in order
module vga_copy_checker
   import vga_copy_pkg::*;
#(
   parameter int unsigned ADDR_W = VGA_ADDR_W,
   parameter int unsigned WORDS  = VGA_WORDS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              cap,
   input  logic [ADDR_W-1:0] cap_addr,
   output logic [ADDR_W:0]   words,
   output logic              ok_c
);

   localparam int unsigned CNT_W = ADDR_W + 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bad_q, bad_d;

   // Word i of a good copy carries address i; comparing against the running
   // count in CNT_W bits also flags any word beyond WORDS (count MSB set).
   always_comb begin
      cnt_d = cnt_q;
      bad_d = bad_q;
      if (clr) begin
         cnt_d = '0;
         bad_d = 1'b0;
      end else if (cap) begin
         if ({1'b0, cap_addr} != cnt_q) begin
            bad_d = 1'b1;
         end
         if (cnt_q != CNT_W'(WORDS)) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         bad_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         bad_q <= bad_d;
      end
   end

   assign words = cnt_q;
   assign ok_c  = (cnt_q == CNT_W'(WORDS)) && !bad_q;

endmodule

// File: rtl/vga_copy_sched.sv
// Frame copy scheduler: starts a shared-memory image copy on request,
// forwards the streamed words to the framebuffer one cycle later, checks the
// copy for completeness/ordering and (optionally) swaps display buffers on
// the next vertical blank.
// Build option: VGA_COPY_DOUBLE_BUF_EN enables double buffering (SWAP state,
// fb_front toggling, frame_tick use). Without it the copy always targets
// buffer 0 and done pulses straight out of CHECK.
//   clk, reset         : clock, synchronous active-high reset
//   copy_req           : copy request (merged into one pending if busy)
//   err_clr            : clears sticky err
//   frame_tick         : vertical blank start
//   vga_en             : one-cycle copy start pulse to shared memory
//   sh_copy/addr/data  : streamed word valid, address, data
//   sh_end             : shared memory not copying
//   fb_we/addr/data    : framebuffer write port (addr MSB = buffer)
//   fb_front           : buffer being displayed
//   busy, done, err    : status; words = words of last/current copy
module vga_copy_sched
   import vga_copy_pkg::*;
#(
   parameter int unsigned ADDR_W      = VGA_ADDR_W,
   parameter int unsigned DATA_W      = VGA_DATA_W,
   parameter int unsigned TIMEOUT_CYC = VGA_TIMEOUT_CYC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              copy_req,
   input  logic              err_clr,
   input  logic              frame_tick,
   output logic              vga_en,
   input  logic              sh_copy,
   input  logic [ADDR_W-1:0] sh_addr,
   input  logic [DATA_W-1:0] sh_data,
   input  logic              sh_end,
   output logic              fb_we,
   output logic [ADDR_W:0]   fb_addr,
   output logic [DATA_W-1:0] fb_data,
   output logic              fb_front,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   words
);

   localparam int unsigned WORDS = 1 << ADDR_W;
   localparam int unsigned TO_W  = $clog2(TIMEOUT_CYC + 1);

   vga_copy_state_e   state_q, state_d;
   logic              pending_q, pending_d;
   logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
   logic              vga_en_q, vga_en_d;
   logic              fb_we_q, fb_we_d;
   logic [ADDR_W:0]   fb_addr_q, fb_addr_d;
   logic [DATA_W-1:0] fb_data_q, fb_data_d;
   logic              fb_front_q, fb_front_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              start_c;
   logic              cap_c;
   logic              err_set_c;
   logic              back_c;
   logic              ok_c;

`ifdef VGA_COPY_DOUBLE_BUF_EN
   assign back_c = ~fb_front_q;
`else
   assign back_c = 1'b0;
   logic unused_frame_tick;
   assign unused_frame_tick = frame_tick;
`endif

   // A streamed word is taken in WAIT (first word) and throughout COPY.
   assign cap_c = sh_copy && ((state_q == ST_WAIT) || (state_q == ST_COPY));

   vga_copy_checker #(
      .ADDR_W (ADDR_W),
      .WORDS  (WORDS)
   ) u_checker (
      .clk      (clk),
      .reset    (reset),
      .clr      (start_c),
      .cap      (cap_c),
      .cap_addr (sh_addr),
      .words    (words),
      .ok_c     (ok_c)
   );

   // Next-state and registered-output logic.
   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      to_cnt_d   = to_cnt_q;
      vga_en_d   = 1'b0;
      fb_we_d    = 1'b0;
      fb_addr_d  = fb_addr_q;
      fb_data_d  = fb_data_q;
      fb_front_d = fb_front_q;
      done_d     = 1'b0;
      start_c    = 1'b0;
      err_set_c  = 1'b0;

      if (copy_req && (state_q != ST_IDLE)) begin
         pending_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (copy_req || pending_q) begin
               state_d   = ST_START;
               pending_d = 1'b0;
               start_c   = 1'b1;
               vga_en_d  = 1'b1;
            end
         end
         ST_START: begin
            to_cnt_d = '0;
            state_d  = ST_WAIT;
         end
         ST_WAIT: begin
            if (sh_copy) begin
               state_d = ST_COPY;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
               if (to_cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                  err_set_c = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
         end
         ST_COPY: begin
            if (!sh_copy && sh_end) begin
               state_d = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (!ok_c) begin
               err_set_c = 1'b1;
            end
`ifdef VGA_COPY_DOUBLE_BUF_EN
            state_d = ST_SWAP;
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
         end
`ifdef VGA_COPY_DOUBLE_BUF_EN
         ST_SWAP: begin
            if (frame_tick) begin
               fb_front_d = ~fb_front_q;
               done_d     = 1'b1;
               state_d    = ST_IDLE;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Forward each captured word to the back buffer one cycle later.
      if (cap_c) begin
         fb_we_d   = 1'b1;
         fb_addr_d = {back_c, sh_addr};
         fb_data_d = sh_data;
      end

      // A new error takes priority over a simultaneous clear.
      err_d = err_q;
      if (err_clr) begin
         err_d = 1'b0;
      end
      if (err_set_c) begin
         err_d = 1'b1;
      end

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         pending_q  <= 1'b0;
         to_cnt_q   <= '0;
         vga_en_q   <= 1'b0;
         fb_we_q    <= 1'b0;
         fb_addr_q  <= '0;
         fb_data_q  <= '0;
         fb_front_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pending_q  <= pending_d;
         to_cnt_q   <= to_cnt_d;
         vga_en_q   <= vga_en_d;
         fb_we_q    <= fb_we_d;
         fb_addr_q  <= fb_addr_d;
         fb_data_q  <= fb_data_d;
         fb_front_q <= fb_front_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign vga_en   = vga_en_q;
   assign fb_we    = fb_we_q;
   assign fb_addr  = fb_addr_q;
   assign fb_data  = fb_data_q;
   assign fb_front = fb_front_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;

endmodule

// File: tb/tb_vga_copy_sched.sv
// Self-checking bench for vga_copy_sched: randomized streams (data, gaps,
// lead-in delay, corruption position) checked against expectations derived
// from the copy rules (write = driven word one cycle later into the back
// buffer; err iff count != WORDS or some address i != i).
module tb_vga_copy_sched;
   import vga_copy_pkg::*;

   localparam int unsigned ADDR_W      = 12;
   localparam int unsigned DATA_W      = 8;
   localparam int unsigned WORDS       = 1 << ADDR_W;
   localparam int unsigned TIMEOUT_CYC = 16;

   logic              clk = 1'b0;
   logic              reset, copy_req, err_clr, frame_tick;
   logic              sh_copy, sh_end;
   logic [ADDR_W-1:0] sh_addr;
   logic [DATA_W-1:0] sh_data;
   logic              vga_en, fb_we, fb_front, busy, done, err;
   logic [ADDR_W:0]   fb_addr, words;
   logic [DATA_W-1:0] fb_data;

   int n_checks = 0;
   int n_pass   = 0;
   int en_cnt   = 0;
   int done_cnt = 0;
   logic model_front = 1'b0;

   vga_copy_sched #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .copy_req   (copy_req),
      .err_clr    (err_clr),
      .frame_tick (frame_tick),
      .vga_en     (vga_en),
      .sh_copy    (sh_copy),
      .sh_addr    (sh_addr),
      .sh_data    (sh_data),
      .sh_end     (sh_end),
      .fb_we      (fb_we),
      .fb_addr    (fb_addr),
      .fb_data    (fb_data),
      .fb_front   (fb_front),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .words      (words)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled away from the active edge.
   always @(negedge clk) begin
      if (vga_en === 1'b1) en_cnt++;
      if (done === 1'b1) done_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic back_sel();
`ifdef VGA_COPY_DOUBLE_BUF_EN
      return ~model_front;
`else
      return 1'b0;
`endif
   endfunction

   task automatic clear_err();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
   endtask

   // Issues copy_req; returns vga_en seen in the following cycle. Ends in
   // the first WAIT cycle.
   task automatic request(output logic en_seen);
      copy_req = 1'b1;
      tick();
      copy_req = 1'b0;
      en_seen  = vga_en;
      sh_end   = 1'b0;
      tick();
   endtask

   // Streams n words (address i, except address i+1 at bad_idx) with random
   // data, lead-in delay and gaps; counts correct and wrong fb writes.
   task automatic stream(input int n, input int bad_idx, input bit req_mid,
                         output int wr_bad, output int wr_ok);
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d;
      logic [ADDR_W:0]   exp_addr;
      wr_bad = 0;
      wr_ok  = 0;
      repeat ($urandom_range(0, 5)) begin
         tick();
         if (fb_we !== 1'b0) wr_bad++;
      end
      for (int i = 0; i < n; i++) begin
         if (i > 0 && $urandom_range(0, 15) == 0) begin
            sh_copy = 1'b0;
            tick();
            if (fb_we !== 1'b0) wr_bad++;
         end
         a = ADDR_W'(i);
         if (i == bad_idx) a = ADDR_W'(i + 1);
         d = DATA_W'($urandom);
         sh_copy  = 1'b1;
         sh_addr  = a;
         sh_data  = d;
         exp_addr = {back_sel(), a};
         if (req_mid && i == n / 2) copy_req = 1'b1;
         tick();
         copy_req = 1'b0;
         if (fb_we === 1'b1 && fb_addr === exp_addr && fb_data === d) wr_ok++;
         else wr_bad++;
      end
      sh_copy = 1'b0;
      sh_end  = 1'b1;
   endtask

   // Runs CHECK (and SWAP when double buffered); returns observations taken
   // in the done cycle. early_done reports any done before it was due.
   task automatic finish(output logic early_done, output logic done_o,
                         output logic err_o, output logic [ADDR_W:0] words_o,
                         output logic busy_o);
      tick();
      early_done = done;
`ifdef VGA_COPY_DOUBLE_BUF_EN
      frame_tick = 1'b1;
      tick();
      frame_tick = 1'b0;
      err_o      = err;
      words_o    = words;
      early_done = early_done | done;
      repeat ($urandom_range(0, 6)) begin
         tick();
         early_done = early_done | done;
      end
      frame_tick = 1'b1;
      tick();
      frame_tick  = 1'b0;
      done_o      = done;
      busy_o      = busy;
      model_front = ~model_front;
`else
      tick();
      err_o   = err;
      words_o = words;
      done_o  = done;
      busy_o  = busy;
`endif
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_checks++;
      if ({vga_en, fb_we, busy, done, err, fb_front} !== 6'b0)
         $display("FAIL reset_flags: got %b want 000000", {vga_en, fb_we, busy, done, err, fb_front});
      else n_pass++;
      n_checks++;
      if (fb_addr !== '0) $display("FAIL reset_fb_addr: got %h want 0", fb_addr); else n_pass++;
      n_checks++;
      if (fb_data !== '0) $display("FAIL reset_fb_data: got %h want 0", fb_data); else n_pass++;
      n_checks++;
      if (words !== '0) $display("FAIL reset_words: got %0d want 0", words); else n_pass++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_normal_copy();
      logic en_seen, early, done_o, err_o, busy_o;
      logic [ADDR_W:0] words_o;
      int bad, ok, e0, d0;
      e0 = en_cnt;
      d0 = done_cnt;
      request(en_seen);
      n_checks++;
      if (en_seen !== 1'b1) $display("FAIL normal_vga_en: got %b want 1", en_seen); else n_pass++;
      stream(WORDS, -1, 1'b0, bad, ok);
      n_checks++;
      if (bad !== 0 || ok !== WORDS)
         $display("FAIL normal_writes: got ok=%0d bad=%0d want ok=%0d bad=0", ok, bad, WORDS);
      else n_pass++;
      finish(early, done_o, err_o, words_o, busy_o);
      n_checks++;
      if (early !== 1'b0 || done_o !== 1'b1)
         $display("FAIL normal_done: got early=%b done=%b want 0/1", early, done_o);
      else n_pass++;
      n_checks++;
      if (err_o !== 1'b0) $display("FAIL normal_err: got %b want 0", err_o); else n_pass++;
      n_checks++;
      if (words_o !== (ADDR_W + 1)'(WORDS))
         $display("FAIL normal_words: got %0d want %0d", words_o, WORDS);
      else n_pass++;
      n_checks++;
      if (busy_o !== 1'b0 || fb_front !== model_front)
         $display("FAIL normal_front: got busy=%b front=%b want 0/%b", busy_o, fb_front, model_front);
      else n_pass++;
      tick();
      n_checks++;
      if (en_cnt - e0 !== 1 || done_cnt - d0 !== 1)
         $display("FAIL normal_pulses: got en=%0d done=%0d want 1/1", en_cnt - e0, done_cnt - d0);
      else n_pass++;
   endtask

   task automatic test_timeout();
      logic en_seen;
      int d0;
      d0 = done_cnt;
      request(en_seen);
      repeat (TIMEOUT_CYC - 1) tick();
      n_checks++;
      if (err !== 1'b0) $display("FAIL timeout_early: got err=%b want 0", err); else n_pass++;
      tick();
      n_checks++;
      if (err !== 1'b1) $display("FAIL timeout_err: got %b want 1", err); else n_pass++;
      tick();
      n_checks++;
      if (busy !== 1'b0 || done_cnt - d0 !== 0)
         $display("FAIL timeout_idle: got busy=%b dones=%0d want 0/0", busy, done_cnt - d0);
      else n_pass++;
      sh_end = 1'b1;
      clear_err();
      n_checks++;
      if (err !== 1'b0) $display("FAIL timeout_clr: got %b want 0", err); else n_pass++;
   endtask

   task automatic test_short_stream();
      logic en_seen, early, done_o, err_o, busy_o;
      logic [ADDR_W:0] words_o;
      int bad, ok;
      request(en_seen);
      stream(WORDS - 1, -1, 1'b0, bad, ok);
      finish(early, done_o, err_o, words_o, busy_o);
      n_checks++;
      if (err_o !== 1'b1 || words_o !== (ADDR_W + 1)'(WORDS - 1))
         $display("FAIL short_err: got err=%b words=%0d want 1/%0d", err_o, words_o, WORDS - 1);
      else n_pass++;
      n_checks++;
      if (early !== 1'b0 || done_o !== 1'b1 || fb_front !== model_front)
         $display("FAIL short_done: got early=%b done=%b front=%b want 0/1/%b", early, done_o, fb_front, model_front);
      else n_pass++;
      n_checks++;
      if (bad !== 0) $display("FAIL short_writes: got bad=%0d want 0", bad); else n_pass++;
      clear_err();
   endtask

   task automatic test_disorder();
      logic en_seen, early, done_o, err_o, busy_o;
      logic [ADDR_W:0] words_o;
      int bad, ok, idx;
      // Stream 0,1,3.
      request(en_seen);
      stream(3, 2, 1'b0, bad, ok);
      finish(early, done_o, err_o, words_o, busy_o);
      n_checks++;
      if (err_o !== 1'b1 || words_o !== (ADDR_W + 1)'(3) || done_o !== 1'b1)
         $display("FAIL disorder3: got err=%b words=%0d done=%b want 1/3/1", err_o, words_o, done_o);
      else n_pass++;
      clear_err();
      // Full-length stream with one misplaced address: only ordering fails.
      idx = int'($urandom_range(1, WORDS - 2));
      request(en_seen);
      stream(WORDS, idx, 1'b0, bad, ok);
      finish(early, done_o, err_o, words_o, busy_o);
      n_checks++;
      if (err_o !== 1'b1 || words_o !== (ADDR_W + 1)'(WORDS))
         $display("FAIL disorder_full: got err=%b words=%0d want 1/%0d (idx %0d)", err_o, words_o, WORDS, idx);
      else n_pass++;
      n_checks++;
      if (bad !== 0) $display("FAIL disorder_writes: got bad=%0d want 0", bad); else n_pass++;
      clear_err();
   endtask

   task automatic test_back_to_back();
      logic en_seen, early, done_o, err_o, busy_o;
      logic [ADDR_W:0] words_o;
      int bad, ok, e0, d0, n1, n2;
      e0 = en_cnt;
      d0 = done_cnt;
      n1 = int'($urandom_range(5, 20));
      n2 = int'($urandom_range(5, 20));
      request(en_seen);
      stream(n1, -1, 1'b1, bad, ok);
      finish(early, done_o, err_o, words_o, busy_o);
      copy_req = 1'b1;
      tick();
      copy_req = 1'b0;
      n_checks++;
      if (vga_en !== 1'b1) $display("FAIL b2b_restart: got vga_en=%b want 1", vga_en); else n_pass++;
      sh_end = 1'b0;
      tick();
      stream(n2, -1, 1'b0, bad, ok);
      finish(early, done_o, err_o, words_o, busy_o);
      n_checks++;
      if (words_o !== (ADDR_W + 1)'(n2) || done_o !== 1'b1)
         $display("FAIL b2b_second: got words=%0d done=%b want %0d/1", words_o, done_o, n2);
      else n_pass++;
      repeat (20) tick();
      n_checks++;
      if (en_cnt - e0 !== 2 || done_cnt - d0 !== 2 || busy !== 1'b0)
         $display("FAIL b2b_pulses: got en=%0d done=%0d busy=%b want 2/2/0", en_cnt - e0, done_cnt - d0, busy);
      else n_pass++;
      clear_err();
   endtask

   task automatic test_reset_mid_copy();
      logic en_seen, early, done_o, err_o, busy_o;
      logic [ADDR_W:0] words_o;
      int bad, ok, d0;
      request(en_seen);
      stream(100, -1, 1'b0, bad, ok);
      d0       = done_cnt;
      sh_copy  = 1'b1;
      sh_end   = 1'b0;
      sh_addr  = ADDR_W'(100);
      reset    = 1'b1;
      tick();
      model_front = 1'b0;
      n_checks++;
      if (fb_we !== 1'b0 || busy !== 1'b0 || words !== '0 || fb_front !== 1'b0)
         $display("FAIL rst_mid: got we=%b busy=%b words=%0d front=%b want 0/0/0/0", fb_we, busy, words, fb_front);
      else n_pass++;
      reset   = 1'b0;
      sh_copy = 1'b0;
      sh_end  = 1'b1;
      repeat (5) tick();
      n_checks++;
      if (done_cnt - d0 !== 0 || fb_we !== 1'b0)
         $display("FAIL rst_quiet: got dones=%0d we=%b want 0/0", done_cnt - d0, fb_we);
      else n_pass++;
      request(en_seen);
      stream(WORDS, -1, 1'b0, bad, ok);
      finish(early, done_o, err_o, words_o, busy_o);
      n_checks++;
      if (err_o !== 1'b0 || words_o !== (ADDR_W + 1)'(WORDS) || done_o !== 1'b1 || bad !== 0)
         $display("FAIL rst_recopy: got err=%b words=%0d done=%b bad=%0d want 0/%0d/1/0", err_o, words_o, done_o, bad, WORDS);
      else n_pass++;
      n_checks++;
      if (fb_front !== model_front)
         $display("FAIL rst_front: got %b want %b", fb_front, model_front);
      else n_pass++;
   endtask

   initial begin
      reset      = 1'b1;
      copy_req   = 1'b0;
      err_clr    = 1'b0;
      frame_tick = 1'b0;
      sh_copy    = 1'b0;
      sh_end     = 1'b1;
      sh_addr    = '0;
      sh_data    = '0;
      test_reset();
      test_normal_copy();
      test_timeout();
      test_short_stream();
      test_disorder();
      test_back_to_back();
      test_reset_mid_copy();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
